// File: rtl/debug_scan_ctrl_pkg.sv
// Shared types and constants for the debug register scan controller.
package debug_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StPresent,
    StGap
  } scan_state_e;

  localparam int unsigned ScanLen = 23;

  localparam logic [1:0] GrpGpr  = 2'b00;
  localparam logic [1:0] GrpCsr  = 2'b01;
  localparam logic [1:0] GrpCore = 2'b11;

  localparam logic [3:0] RegPc = 4'b1110;
  localparam logic [3:0] RegIr = 4'b1111;

  // Scan index to {sel, reg_sel}: 16 GPRs, 5 CSRs, then pc and ir.
  function automatic logic [5:0] idx_to_tag(input logic [4:0] idx);
    logic [5:0] tag;
    if (idx < 5'd16) begin
      tag = {GrpGpr, idx[3:0]};
    end else if (idx < 5'd21) begin
      tag = {GrpCsr, idx[3:0]};
    end else if (idx == 5'd21) begin
      tag = {GrpCore, RegPc};
    end else begin
      tag = {GrpCore, RegIr};
    end
    return tag;
  endfunction

endpackage

// File: rtl/debug_scan_cnt.sv
// Settle and gap counters for debug_scan_ctrl; the gap counter exists only
// when DEBUG_SCAN_AUTO_EN is defined.
module debug_scan_cnt (
  input  logic        clk,
  input  logic        rst,
`ifdef DEBUG_SCAN_AUTO_EN
  input  logic        gap_clr_i,
  input  logic        gap_inc_i,
  output logic [15:0] gap_cnt_o,
`endif
  input  logic        settle_clr_i,
  input  logic        settle_inc_i,
  output logic [3:0]  settle_cnt_o
);

  logic [3:0] settle_q, settle_d;

  always_comb begin
    settle_d = settle_q;
    if (settle_clr_i) begin
      settle_d = '0;
    end else if (settle_inc_i) begin
      settle_d = settle_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_q <= '0;
    end else begin
      settle_q <= settle_d;
    end
  end

  assign settle_cnt_o = settle_q;

`ifdef DEBUG_SCAN_AUTO_EN
  logic [15:0] gap_q, gap_d;

  always_comb begin
    gap_d = gap_q;
    if (gap_clr_i) begin
      gap_d = '0;
    end else if (gap_inc_i) begin
      gap_d = gap_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end

  assign gap_cnt_o = gap_q;
`endif

endmodule

// File: rtl/debug_scan_ctrl.sv
// Walks the debug register readout mux through a fixed 23-entry scan list and
// streams each value out over a valid/ready handshake. Define DEBUG_SCAN_AUTO_EN
// to rescan automatically AUTO_GAP cycles after each completed scan.
module debug_scan_ctrl
  import debug_scan_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned AUTO_GAP   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        abort_i,
  output logic [1:0]  sel_o,
  output logic [3:0]  reg_sel_o,
  input  logic [15:0] reg_data_i,
  output logic [15:0] out_data_o,
  output logic [5:0]  out_tag_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        out_last_o,
  output logic        busy_o
);

  if (SETTLE_CYC < 1 || SETTLE_CYC > 15 || AUTO_GAP < 1 || AUTO_GAP > 65535) begin : g_param_check
    $error("debug_scan_ctrl: SETTLE_CYC or AUTO_GAP out of range");
  end

  localparam logic [3:0] SettleLast = 4'(SETTLE_CYC - 1);
  localparam logic [4:0] IdxLast    = 5'(ScanLen - 1);

  scan_state_e state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [15:0] out_data_q;
  logic [5:0]  out_tag_q;
  logic [5:0]  cur_tag;
  logic        capture;
  logic        settle_clr, settle_inc;
  logic [3:0]  settle_cnt;

`ifdef DEBUG_SCAN_AUTO_EN
  localparam logic [15:0] GapLast = 16'(AUTO_GAP - 1);
  logic        gap_clr, gap_inc;
  logic [15:0] gap_cnt;
`endif

  debug_scan_cnt u_cnt (
    .clk          (clk),
    .rst          (rst),
`ifdef DEBUG_SCAN_AUTO_EN
    .gap_clr_i    (gap_clr),
    .gap_inc_i    (gap_inc),
    .gap_cnt_o    (gap_cnt),
`endif
    .settle_clr_i (settle_clr),
    .settle_inc_i (settle_inc),
    .settle_cnt_o (settle_cnt)
  );

  assign cur_tag = idx_to_tag(idx_q);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    capture    = 1'b0;
    settle_clr = 1'b0;
    settle_inc = 1'b0;
`ifdef DEBUG_SCAN_AUTO_EN
    gap_clr    = 1'b0;
    gap_inc    = 1'b0;
`endif
    if (abort_i) begin
      state_d = StIdle;
      idx_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            state_d    = StSettle;
            idx_d      = '0;
            settle_clr = 1'b1;
          end
        end
        StSettle: begin
          settle_inc = 1'b1;
          if (settle_cnt == SettleLast) begin
            capture = 1'b1;
            state_d = StPresent;
          end
        end
        StPresent: begin
          if (out_ready_i) begin
            if (idx_q == IdxLast) begin
`ifdef DEBUG_SCAN_AUTO_EN
              state_d = StGap;
              gap_clr = 1'b1;
`else
              state_d = StIdle;
`endif
              idx_d   = '0;
            end else begin
              state_d    = StSettle;
              idx_d      = idx_q + 5'd1;
              settle_clr = 1'b1;
            end
          end
        end
`ifdef DEBUG_SCAN_AUTO_EN
        StGap: begin
          gap_inc = 1'b1;
          if (gap_cnt == GapLast) begin
            state_d    = StSettle;
            idx_d      = '0;
            settle_clr = 1'b1;
          end
        end
`endif
        default: begin
          state_d = StIdle;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      out_data_q <= '0;
      out_tag_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (capture) begin
        out_data_q <= reg_data_i;
        out_tag_q  <= cur_tag;
      end
    end
  end

  // The mux select is only driven while an entry is being read or presented.
  always_comb begin
    sel_o     = 2'b00;
    reg_sel_o = 4'b0000;
    if (state_q == StSettle || state_q == StPresent) begin
      {sel_o, reg_sel_o} = cur_tag;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_tag_o   = out_tag_q;
  assign out_valid_o = (state_q == StPresent);
  assign out_last_o  = (state_q == StPresent) && (idx_q == IdxLast);
  assign busy_o      = (state_q != StIdle);

endmodule

// File: doc/debug_scan_ctrl.md
DEBUG_SCAN_CTRL -- requirements
Module: debug_scan_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 2: cycles the select code is held before reg_data is captured; legal range 1..15.
REQ-002 Parameter AUTO_GAP, default 1024: idle cycles between automatic rescans; legal range 1..65535.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  one-cycle request to begin a scan.
REQ-006 abort  in  1  terminates any scan in progress.
REQ-007 sel  out  2  group select driven to the register readout mux.
REQ-008 reg_sel  out  4  register select driven to the register readout mux.
REQ-009 reg_data  in  16  mux output, sampled after settling.
REQ-010 out_data  out  16  captured register value.
REQ-011 out_tag  out  6  {sel,reg_sel} of the captured value.
REQ-012 out_valid / out_ready  out / in  1 / 1  output handshake; a transfer occurs when both are high on a clock edge.
REQ-013 out_last  out  1  high with the final entry of a scan.
REQ-014 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-015 Scan list, 23 entries, index 0..22: idx 0..15 -> sel=00, reg_sel=idx; idx 16..20 -> sel=01, reg_sel=idx-16; idx 21 -> 11/1110 (pc); idx 22 -> 11/1111 (ir).
REQ-016 States: IDLE, SETTLE, PRESENT, GAP; GAP exists only under REQ-026.
REQ-017 IDLE: start=1 -> idx=0, settle counter=0, go to SETTLE; sel/reg_sel hold 00/0000.
REQ-018 SETTLE: sel/reg_sel driven from idx; counter increments each cycle; on the cycle counter==SETTLE_CYC-1, out_data<=reg_data, out_tag<={sel,reg_sel}, go to PRESENT.
REQ-019 PRESENT: out_valid=1; out_data, out_tag and out_last are held stable until the transfer; out_last=1 if and only if idx==22.
REQ-020 Transfer with idx<22 -> idx+1, counter=0, go to SETTLE; transfer with idx==22 -> IDLE, or GAP under REQ-026.
REQ-021 Latency: first out_valid is asserted SETTLE_CYC+1 cycles after the start edge; with out_ready held high, one entry is transferred every SETTLE_CYC+1 cycles.
REQ-022 start is ignored while busy=1.
REQ-023 abort has priority over every other event: from any state -> IDLE next cycle; out_valid=0; no partial transfer is counted. abort together with start in IDLE -> remains IDLE.

Reset
REQ-024 rst=1 -> state IDLE, idx=0, counters=0, sel=00, reg_sel=0000, out_data=0, out_tag=0, out_valid=0, out_last=0, busy=0, applied immediately and independent of clk.
REQ-025 Reset asserted mid-scan discards the scan; after release the block waits for a new start.

Configuration
REQ-026 Macro DEBUG_SCAN_AUTO_EN. Defined: after the last transfer, go to GAP and count AUTO_GAP cycles, then restart at idx=0 in SETTLE with no start required; start is ignored in GAP; abort in GAP -> IDLE and auto mode stays stopped until the next start; busy=1 in GAP. Not defined: no GAP state, scans run only on start.

Structure
REQ-027 Shared package holds: the state enumeration, the scan-length constant (23), the group codes (00/01/11), the pc/ir codes (1110/1111), and an index-to-{sel,reg_sel} mapping function.
REQ-028 One sub-module, debug_scan_cnt, implements the settle counter and the gap counter; all other logic is flat.

Verification
REQ-029 SETTLE_CYC=2, out_ready=1, mux model returns {10'h0,tag}: start -> 23 transfers with tags 00_0000..00_1111, 01_0000..01_0100, 11_1110, 11_1111; out_last only on 11_1111; transfers spaced 3 cycles apart; first out_valid 3 cycles after start.
REQ-030 out_ready low for 5 cycles at idx=7 -> out_valid stays high, out_data/out_tag stable, idx does not advance; scan completes with 23 transfers.
REQ-031 abort at idx=10 during PRESENT -> IDLE next cycle, out_valid=0, busy=0; a new start restarts at tag 00_0000.
REQ-032 start pulses at idx=5 -> ignored, no restart; simultaneous start and abort in IDLE -> remains IDLE.
REQ-033 async rst pulsed between clock edges mid-scan -> all outputs reach reset values before the next edge.
REQ-034 DEBUG_SCAN_AUTO_EN defined, AUTO_GAP=4 -> second scan begins 4 cycles after the first out_last transfer with no start; abort in GAP stops auto rescans.
